// File: rtl/fp_add_control_if.sv
// fp_add_control_if: control/readback bundle between the FP add/sub sequencer and its datapath
interface fp_add_control_if #(
   parameter int FRAC_W = 26,
   parameter int EXP_W  = 8,
   parameter int SH_W   = 5
);
   logic              start;
   logic              eff_sub;
   logic [EXP_W-1:0]  exp_diff_in;
   logic [FRAC_W-1:0] ula_result;
   logic              round_ovf_in;
   logic [SH_W-1:0]   tamanho;
   logic [SH_W-1:0]   tamanho2;
   logic [EXP_W-1:0]  tamanho3;
   logic              soma_multiplica_small_ula;
   logic              soma_multiplica_big_ula;
   logic              subtrador_big_ula;
   logic              decisor_mux_expoente_escolhido;
   logic              decisor_mux_saida_big_ula;
   logic              decisor_shift_right_left;
   logic              subtrador_Somador_subtrador;
   logic              load;
   logic              busy;
   logic              done;
   logic              zero_out;
   logic              renorm_err;
   modport master (
      input  start, eff_sub, exp_diff_in, ula_result, round_ovf_in,
      output tamanho, tamanho2, tamanho3, soma_multiplica_small_ula, soma_multiplica_big_ula,
             subtrador_big_ula, decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula,
             decisor_shift_right_left, subtrador_Somador_subtrador, load, busy, done,
             zero_out, renorm_err
   );
   modport slave (
      output start, eff_sub, exp_diff_in, ula_result, round_ovf_in,
      input  tamanho, tamanho2, tamanho3, soma_multiplica_small_ula, soma_multiplica_big_ula,
             subtrador_big_ula, decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula,
             decisor_shift_right_left, subtrador_Somador_subtrador, load, busy, done,
             zero_out, renorm_err
   );
endinterface

// File: rtl/fp_add_control.sv
// fp_add_control: start/done sequencer stepping the FP add/sub datapath through
// compare, align, add/sub, normalize, round and optional re-normalization.
module fp_add_control #(
   parameter int FRAC_W     = 26,
   parameter int EXP_W      = 8,
   parameter int SH_W       = 5,
   parameter int MAX_RENORM = 1
) (
   input logic clk,
   input logic reset,
   fp_add_control_if.master bus
);
   typedef enum logic [3:0] {
      IDLE, EXP, ALIGN, CALC, SET_E, LD_E, SET_N, LD_N, CHECK, SET_R, LD_R, DONE
   } state_t;
   localparam int CW = $clog2(MAX_RENORM + 2);
   state_t state_q, state_d;
   logic eff_sub_q, zero_q, err_q;
   logic [CW-1:0] cnt_q;
   logic [EXP_W-1:0] diff_q, tamanho3_q, tamanho3_d;
   logic [SH_W-1:0] lz_q, lz_d, tamanho_q, tamanho2_q, tamanho2_d;
   logic small_q, small_d, big_q, big_d, sub_big_q, sub_big_d, mux_exp_q, mux_exp_d;
   logic mux_saida_q, mux_saida_d, left_q, left_d, sub_som_q, sub_som_d;
   logic load_q, load_d, busy_q, busy_d, done_q, done_d;
   logic ula_zero, in_e, in_n, in_r;
   assign ula_zero = bus.ula_result == '0;
   always_comb begin
      lz_d = '0;
      for (int i = 0; i < FRAC_W; i++)
         if (bus.ula_result[i]) lz_d = SH_W'(FRAC_W - 1 - i);
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.start ? EXP : IDLE;
         EXP:     state_d = ALIGN;
         ALIGN:   state_d = CALC;
         CALC:    state_d = ula_zero ? DONE : SET_E;
         SET_E:   state_d = LD_E;
         LD_E:    state_d = SET_N;
         SET_N:   state_d = LD_N;
         LD_N:    state_d = CHECK;
         CHECK:   state_d = (bus.round_ovf_in && cnt_q < CW'(MAX_RENORM)) ? SET_R : DONE;
         SET_R:   state_d = LD_R;
         LD_R:    state_d = CHECK;
         default: state_d = IDLE;
      endcase
      // outputs are registered from the state being entered, so they line up with it
      in_e        = state_d == SET_E || state_d == LD_E;
      in_n        = state_d == SET_N || state_d == LD_N;
      in_r        = state_d == SET_R || state_d == LD_R;
      small_d     = state_d == EXP;
      big_d       = state_d == CALC;
      sub_big_d   = state_d == CALC && eff_sub_q;
      mux_exp_d   = in_n || in_r;
      mux_saida_d = in_r;
      left_d      = in_n;
      sub_som_d   = in_n;
      load_d      = state_d == LD_E || state_d == LD_N || state_d == LD_R;
      tamanho2_d  = in_n ? lz_q : in_r ? SH_W'(1) : '0;
      tamanho3_d  = in_e ? diff_q : in_n ? EXP_W'(lz_q) : in_r ? EXP_W'(1) : '0;
      done_d      = state_d == DONE;
      busy_d      = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         eff_sub_q   <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         diff_q      <= '0;
         lz_q        <= '0;
         tamanho_q   <= '0;
         tamanho2_q  <= '0;
         tamanho3_q  <= '0;
         small_q     <= 1'b0;
         big_q       <= 1'b0;
         sub_big_q   <= 1'b0;
         mux_exp_q   <= 1'b0;
         mux_saida_q <= 1'b0;
         left_q      <= 1'b0;
         sub_som_q   <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tamanho2_q  <= tamanho2_d;
         tamanho3_q  <= tamanho3_d;
         small_q     <= small_d;
         big_q       <= big_d;
         sub_big_q   <= sub_big_d;
         mux_exp_q   <= mux_exp_d;
         mux_saida_q <= mux_saida_d;
         left_q      <= left_d;
         sub_som_q   <= sub_som_d;
         load_q      <= load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         if (state_q == IDLE && bus.start) begin
            eff_sub_q <= bus.eff_sub;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
         end
         if (state_q == ALIGN) begin
            tamanho_q <= (bus.exp_diff_in >= EXP_W'(FRAC_W)) ? SH_W'(FRAC_W) : bus.exp_diff_in[SH_W-1:0];
            diff_q    <= bus.exp_diff_in;
         end
         if (state_q == CALC) begin
            lz_q   <= lz_d;
            zero_q <= ula_zero;
         end
         if (state_q == CHECK && bus.round_ovf_in) begin
            if (cnt_q < CW'(MAX_RENORM)) cnt_q <= cnt_q + CW'(1);
            else err_q <= 1'b1;
         end
      end
   end
   assign bus.tamanho                        = tamanho_q;
   assign bus.tamanho2                       = tamanho2_q;
   assign bus.tamanho3                       = tamanho3_q;
   assign bus.soma_multiplica_small_ula      = small_q;
   assign bus.soma_multiplica_big_ula        = big_q;
   assign bus.subtrador_big_ula              = sub_big_q;
   assign bus.decisor_mux_expoente_escolhido = mux_exp_q;
   assign bus.decisor_mux_saida_big_ula      = mux_saida_q;
   assign bus.decisor_shift_right_left       = left_q;
   assign bus.subtrador_Somador_subtrador    = sub_som_q;
   assign bus.load                           = load_q;
   assign bus.busy                           = busy_q;
   assign bus.done                           = done_q;
   assign bus.zero_out                       = zero_q;
   assign bus.renorm_err                     = err_q;
endmodule

// File: tb/tb_fp_add_control.sv
// tb_fp_add_control: directed checks of the FP add/sub sequencer timing and control values
module tb_fp_add_control;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int passed = 0;
   fp_add_control_if #(.FRAC_W(26), .EXP_W(8), .SH_W(5)) bus();
   fp_add_control #(.FRAC_W(26), .EXP_W(8), .SH_W(5), .MAX_RENORM(1)) dut (
      .clk(clk), .reset(reset), .bus(bus.master)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic go(input logic sub, input logic [7:0] diff, input logic [25:0] ula);
      bus.eff_sub = sub;
      bus.exp_diff_in = diff;
      bus.ula_result = ula;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_load"}, 32'(bus.load), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_t2"}, 32'(bus.tamanho2), 0);
      chk({tag, "_t3"}, 32'(bus.tamanho3), 0);
      chk({tag, "_ctl"}, 32'({bus.soma_multiplica_small_ula, bus.soma_multiplica_big_ula,
                              bus.subtrador_big_ula, bus.decisor_mux_expoente_escolhido,
                              bus.decisor_mux_saida_big_ula, bus.decisor_shift_right_left,
                              bus.subtrador_Somador_subtrador}), 0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.eff_sub = 1'b0;
      bus.exp_diff_in = '0;
      bus.ula_result = '0;
      bus.round_ovf_in = 1'b0;
      step(2);
      chk_idle_outputs("rst");
      chk("rst_tam", 32'(bus.tamanho), 0);
      reset = 1'b0;
      step(1);
      chk_idle_outputs("post_rst");
      // normal add: bit 25 set -> lz 0
      go(1'b0, 8'd3, 26'h2000000);
      chk("add_c1_small", 32'(bus.soma_multiplica_small_ula), 1);
      chk("add_c1_busy", 32'(bus.busy), 1);
      step(2);
      chk("add_c3_tam", 32'(bus.tamanho), 3);
      chk("add_c3_big", 32'(bus.soma_multiplica_big_ula), 1);
      chk("add_c3_sub", 32'(bus.subtrador_big_ula), 0);
      chk("add_c3_load", 32'(bus.load), 0);
      step(1);
      chk("add_c4_load", 32'(bus.load), 0);
      chk("add_c4_t3", 32'(bus.tamanho3), 3);
      step(1);
      chk("add_c5_load", 32'(bus.load), 1);
      chk("add_c5_t3", 32'(bus.tamanho3), 3);
      chk("add_c5_mux_sub", 32'({bus.decisor_mux_expoente_escolhido, bus.subtrador_Somador_subtrador}), 0);
      step(1);
      chk("add_c6_load", 32'(bus.load), 0);
      step(1);
      chk("add_c7_load", 32'(bus.load), 1);
      chk("add_c7_t2", 32'(bus.tamanho2), 0);
      chk("add_c7_t3", 32'(bus.tamanho3), 0);
      chk("add_c7_ctl", 32'({bus.decisor_mux_expoente_escolhido, bus.subtrador_Somador_subtrador,
                             bus.decisor_mux_saida_big_ula, bus.decisor_shift_right_left}), 4'b1101);
      step(1);
      chk("add_c8_done", 32'(bus.done), 0);
      chk("add_c8_load", 32'(bus.load), 0);
      step(1);
      chk("add_c9_done", 32'(bus.done), 1);
      chk("add_c9_zero", 32'(bus.zero_out), 0);
      chk("add_c9_err", 32'(bus.renorm_err), 0);
      step(1);
      chk("add_c10_done", 32'(bus.done), 0);
      chk("add_c10_busy", 32'(bus.busy), 0);
      // cancellation: bit 20 set -> lz 5
      go(1'b1, 8'd0, 26'h0100000);
      step(2);
      chk("can_c3_sub", 32'(bus.subtrador_big_ula), 1);
      chk("can_c3_tam", 32'(bus.tamanho), 0);
      step(4);
      chk("can_c7_load", 32'(bus.load), 1);
      chk("can_c7_t2", 32'(bus.tamanho2), 5);
      chk("can_c7_t3", 32'(bus.tamanho3), 5);
      chk("can_c7_subsom", 32'(bus.subtrador_Somador_subtrador), 1);
      step(1);
      chk("can_c8_done", 32'(bus.done), 0);
      step(1);
      chk("can_c9_done", 32'(bus.done), 1);
      step(1);
      // large difference saturates the alignment shift
      go(1'b0, 8'd40, 26'h1000000);
      step(2);
      chk("big_c3_tam", 32'(bus.tamanho), 26);
      step(2);
      chk("big_c5_t3", 32'(bus.tamanho3), 40);
      step(2);
      chk("big_c7_t2", 32'(bus.tamanho2), 1);
      step(2);
      chk("big_c9_done", 32'(bus.done), 1);
      step(1);
      // zero result, with a start held during done that must be ignored
      go(1'b0, 8'd5, 26'h0);
      chk("zero_c1_load", 32'(bus.load), 0);
      step(1);
      chk("zero_c2_load", 32'(bus.load), 0);
      step(1);
      chk("zero_c3_load", 32'(bus.load), 0);
      chk("zero_c3_done", 32'(bus.done), 0);
      step(1);
      chk("zero_c4_done", 32'(bus.done), 1);
      chk("zero_c4_zero", 32'(bus.zero_out), 1);
      chk("zero_c4_load", 32'(bus.load), 0);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("zero_c5_done", 32'(bus.done), 0);
      chk("zero_c5_busy", 32'(bus.busy), 0);
      chk("zero_c5_zero_hold", 32'(bus.zero_out), 1);
      step(1);
      chk("zero_c6_busy", 32'(bus.busy), 0);
      // rounding overflow persisting -> one pass then error
      go(1'b0, 8'd3, 26'h2000000);
      chk("ovf_c1_zero_clr", 32'(bus.zero_out), 0);
      step(6);
      chk("ovf_c7_load", 32'(bus.load), 1);
      bus.round_ovf_in = 1'b1;
      step(1);
      chk("ovf_c8_load", 32'(bus.load), 0);
      step(1);
      chk("ovf_c9_load", 32'(bus.load), 0);
      chk("ovf_c9_t2", 32'(bus.tamanho2), 1);
      chk("ovf_c9_t3", 32'(bus.tamanho3), 1);
      chk("ovf_c9_ctl", 32'({bus.decisor_mux_expoente_escolhido, bus.subtrador_Somador_subtrador,
                             bus.decisor_mux_saida_big_ula, bus.decisor_shift_right_left}), 4'b1010);
      step(1);
      chk("ovf_c10_load", 32'(bus.load), 1);
      chk("ovf_c10_t2", 32'(bus.tamanho2), 1);
      chk("ovf_c10_right", 32'(bus.decisor_shift_right_left), 0);
      step(1);
      chk("ovf_c11_load", 32'(bus.load), 0);
      chk("ovf_c11_done", 32'(bus.done), 0);
      step(1);
      chk("ovf_c12_done", 32'(bus.done), 1);
      chk("ovf_c12_err", 32'(bus.renorm_err), 1);
      bus.round_ovf_in = 1'b0;
      step(1);
      chk("ovf_c13_err_hold", 32'(bus.renorm_err), 1);
      // overflow cleared after the pass -> no error
      go(1'b0, 8'd3, 26'h2000000);
      chk("ovf2_c1_err_clr", 32'(bus.renorm_err), 0);
      step(6);
      bus.round_ovf_in = 1'b1;
      step(3);
      chk("ovf2_c10_load", 32'(bus.load), 1);
      bus.round_ovf_in = 1'b0;
      step(2);
      chk("ovf2_c12_done", 32'(bus.done), 1);
      chk("ovf2_c12_err", 32'(bus.renorm_err), 0);
      step(1);
      // reset mid-LD_N aborts at once
      go(1'b1, 8'd2, 26'h0100000);
      step(6);
      chk("rmid_c7_load", 32'(bus.load), 1);
      #1 reset = 1'b1;
      #1;
      chk_idle_outputs("rmid");
      step(1);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk($sformatf("rmid_nodone%0d", i), 32'({bus.done, bus.busy}), 0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fp_add_control.md
Name: fp_add_control

Overview:
- Sequencing FSM that sits directly upstream of the FP add/sub datapath and drives all of its control inputs.
- Replaces hand-timed bench stimulus with a start/done handshake.
- Reads back three datapath outputs (registered exponent difference, big-ULA result, rounding overflow) and steps the datapath through: exponent compare, alignment, add/sub, normalization, rounding, and one optional rounding re-normalization.
- Add/sub only; the multiply selects are held at their "add" values.

Parameters:
- FRAC_W, 26, width of the big-ULA result (23 fraction + 3 guard bits).
- EXP_W, 8, exponent width.
- SH_W, 5, alignment/normalization shift-amount width.
- MAX_RENORM, 1, maximum number of rounding-overflow re-normalization passes.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- eff_sub  input  1  effective subtraction (sign_a ^ sign_b); latched on start.
- exp_diff_in  input  EXP_W  registered exponent difference from the datapath.
- ula_result  input  FRAC_W  big-ULA result from the datapath.
- round_ovf_in  input  1  rounding overflow from the datapath.
- tamanho  output  SH_W  alignment right-shift amount.
- tamanho2  output  SH_W  normalization shift amount.
- tamanho3  output  EXP_W  exponent adjust amount.
- soma_multiplica_small_ula  output  1  1 = exponent difference.
- soma_multiplica_big_ula  output  1  1 = add/sub mode.
- subtrador_big_ula  output  1  big-ULA subtract.
- decisor_mux_expoente_escolhido  output  1  0 = smaller exponent, 1 = rounded exponent.
- decisor_mux_saida_big_ula  output  1  0 = ULA result, 1 = rounded fraction.
- decisor_shift_right_left  output  1  1 = left, 0 = right.
- subtrador_Somador_subtrador  output  1  exponent adjust subtract.
- load  output  1  rounding/exponent capture strobe, one cycle wide.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle completion pulse.
- zero_out  output  1  result is zero; valid with done.
- renorm_err  output  1  overflow persisted after MAX_RENORM passes; valid with done.

Behaviour:
- All outputs are registered. Each takes its state value during that state.
- Reset (async) clears state to IDLE and drives every output to 0, including load. Reset mid-operation aborts the operation immediately; there is no done pulse.
- States and transitions:
  - IDLE: on start=1, latch eff_sub, set busy=1, go to EXP. start is ignored while busy.
  - EXP: soma_multiplica_small_ula=1. The datapath registers the difference at the end of this cycle. Go to ALIGN.
  - ALIGN: at the end of the cycle, tamanho <= (exp_diff_in >= 26) ? 26 : exp_diff_in[4:0], and diff_r <= exp_diff_in. Go to CALC.
  - CALC: soma_multiplica_big_ula=1, subtrador_big_ula=eff_sub_r. At the end of the cycle:
    - lz <= leading-zero count of ula_result, range 0..25.
    - If ula_result==0: zero_out<=1, go to DONE.
    - Otherwise go to SET_E.
  - SET_E: decisor_mux_expoente_escolhido=0, subtrador_Somador_subtrador=0, tamanho3=diff_r. Go to LD_E.
  - LD_E: same controls, load=1. Go to SET_N.
  - SET_N: tamanho3={3'b0,lz}, tamanho2=lz, decisor_mux_expoente_escolhido=1, subtrador_Somador_subtrador=1, decisor_mux_saida_big_ula=0, decisor_shift_right_left=1. Go to LD_N.
  - LD_N: same controls, load=1. Go to CHECK.
  - CHECK:
    - If round_ovf_in=1 and pass count < MAX_RENORM: increment the count, go to SET_R.
    - If round_ovf_in=1 and the count is exhausted: renorm_err<=1, go to DONE.
    - Otherwise go to DONE.
  - SET_R: decisor_mux_saida_big_ula=1, decisor_shift_right_left=0, tamanho2=1, decisor_mux_expoente_escolhido=1, subtrador_Somador_subtrador=0, tamanho3=1. Go to LD_R.
  - LD_R: same controls, load=1. Go to CHECK.
  - DONE: done=1, busy=0 at the next edge. Go to IDLE.
- Load rules:
  - load is never high in two consecutive cycles.
  - Every control consumed by a load is stable for the full cycle before and during load.
- Latency (done high, counted in cycles after the start edge):
  - Normal result: 9.
  - Zero result: 4.
  - Each re-normalization pass: +3.
- zero_out and renorm_err are cleared on start acceptance and hold their value after done until the next start.
- A start asserted in the same cycle as done is ignored, because the FSM is not yet in IDLE.

Test Plan:
- Reset check: assert reset mid-LD_N -> load, busy and all controls are 0 in the same cycle; FSM is in IDLE; no done pulse.
- Normal add: start, eff_sub=0, exp_diff_in=3, ula_result=26'h2000000 -> tamanho=3; lz=0; LD_E carries tamanho3=3; LD_N carries tamanho2=0, tamanho3=0; done at cycle 9; zero_out=0.
- Cancellation: eff_sub=1, exp_diff_in=0, ula_result=26'h0100000 -> subtrador_big_ula=1; tamanho2=5; tamanho3=5 with subtract; done at cycle 9.
- Large difference: exp_diff_in=40 -> tamanho=26.
- Zero result: ula_result=0 -> no load pulses; done at cycle 4; zero_out=1.
- Rounding overflow: hold round_ovf_in=1 after LD_N -> one SET_R/LD_R pass with tamanho2=1, right shift, tamanho3=1 add; done at cycle 12; renorm_err=1. Deassert round_ovf_in after LD_R -> renorm_err=0.
